// File: rtl/microseq_controller.sv
// microseq_controller: variable-length SAP control sequencer.
// Decodes the IR opcode into a 16-bit control word. The T-stage advances
// on the falling clock edge. Each instruction returns to fetch right after
// its last active stage. The sequencer also provides a resumable halt and a
// sticky illegal-opcode flag.
// The current state is visible on the stage and halted outputs.
module microseq_controller #(
    parameter int OPCODE_W     = 4,
    parameter int ILLEGAL_HALT = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                carry_in,
    input  logic                zero_in,
    input  logic                resume,
    output logic [15:0]         ctrl,
    output logic [2:0]          stage,
    output logic                instr_done,
    output logic                halted,
    output logic                illegal
);

    // Control word bit positions, MSB to LSB
    localparam logic [15:0] HLT        = 16'h8000;
    localparam logic [15:0] PC_INC     = 16'h4000;
    localparam logic [15:0] PC_LOAD    = 16'h2000;
    localparam logic [15:0] PC_EN      = 16'h1000;
    localparam logic [15:0] MAR_LOAD   = 16'h0800;
    localparam logic [15:0] MEM_ST     = 16'h0400;
    localparam logic [15:0] MEM_EN     = 16'h0200;
    localparam logic [15:0] IR_LOAD    = 16'h0100;
    localparam logic [15:0] IR_EN      = 16'h0080;
    localparam logic [15:0] A_LOAD     = 16'h0040;
    localparam logic [15:0] A_EN       = 16'h0020;
    localparam logic [15:0] B_LOAD     = 16'h0010;
    localparam logic [15:0] ADDER_SUB  = 16'h0008;
    localparam logic [15:0] ADDER_EN   = 16'h0004;
    localparam logic [15:0] FLAGS_LOAD = 16'h0002;
    localparam logic [15:0] OUT_LOAD   = 16'h0001;

    typedef enum logic [2:0] {
        T0 = 3'd0,
        T1 = 3'd1,
        T2 = 3'd2,
        T3 = 3'd3,
        T4 = 3'd4,
        T5 = 3'd5
    } stage_t;

    stage_t stage_q;
    logic   halted_q;
    logic   illegal_q;

    logic       upper_nz;
    logic [3:0] op_lo;
    logic is_lda, is_add, is_sub, is_sta, is_ldi, is_jmp;
    logic is_jc, is_jz, is_out, is_nop, is_hlt;
    logic illegal_op, halt_op, nop_like, mem_op;
    logic last;

    assign op_lo = opcode[3:0];

    // Any set bit above the 4-bit opcode makes the opcode illegal.
    if (OPCODE_W > 4) begin : g_upper
        assign upper_nz = |opcode[OPCODE_W-1:4];
    end else begin : g_no_upper
        assign upper_nz = 1'b0;
    end

    // Opcode decode. An opcode with a nonzero upper bit decodes to nothing.
    always_comb begin
        is_lda = 1'b0;
        is_add = 1'b0;
        is_sub = 1'b0;
        is_sta = 1'b0;
        is_ldi = 1'b0;
        is_jmp = 1'b0;
        is_jc  = 1'b0;
        is_jz  = 1'b0;
        is_out = 1'b0;
        is_nop = 1'b0;
        is_hlt = 1'b0;
        if (!upper_nz) begin
            case (op_lo)
                4'h0:    is_lda = 1'b1;
                4'h1:    is_add = 1'b1;
                4'h2:    is_sub = 1'b1;
                4'h3:    is_sta = 1'b1;
                4'h4:    is_ldi = 1'b1;
                4'h5:    is_jmp = 1'b1;
                4'h6:    is_jc  = 1'b1;
                4'h7:    is_jz  = 1'b1;
                4'h8:    is_out = 1'b1;
                4'h9:    is_nop = 1'b1;
                4'hF:    is_hlt = 1'b1;
                default: ;
            endcase
        end
    end

    assign illegal_op = ~(is_lda | is_add | is_sub | is_sta | is_ldi | is_jmp |
                          is_jc | is_jz | is_out | is_nop | is_hlt);
    assign halt_op    = is_hlt | (illegal_op & (ILLEGAL_HALT != 0));
    assign nop_like   = is_nop | (illegal_op & (ILLEGAL_HALT == 0));
    assign mem_op     = is_lda | is_add | is_sub | is_sta;

    // Control word and last-stage detection from stage, opcode, flags and halt state
    always_comb begin
        ctrl = 16'h0000;
        last = 1'b0;
        if (halted_q) begin
            ctrl = HLT;
        end else begin
            case (stage_q)
                T0: ctrl = PC_EN | MAR_LOAD;
                T1: ctrl = PC_INC;
                T2: ctrl = MEM_EN | IR_LOAD;
                T3: begin
                    if (mem_op) begin
                        ctrl = IR_EN | MAR_LOAD;
                    end else if (is_ldi) begin
                        ctrl = IR_EN | A_LOAD;
                        last = 1'b1;
                    end else if (is_jmp) begin
                        ctrl = IR_EN | PC_LOAD;
                        last = 1'b1;
                    end else if (is_jc) begin
                        ctrl = carry_in ? (IR_EN | PC_LOAD) : 16'h0000;
                        last = 1'b1;
                    end else if (is_jz) begin
                        ctrl = zero_in ? (IR_EN | PC_LOAD) : 16'h0000;
                        last = 1'b1;
                    end else if (is_out) begin
                        ctrl = A_EN | OUT_LOAD;
                        last = 1'b1;
                    end else if (nop_like) begin
                        last = 1'b1;
                    end else if (halt_op) begin
                        ctrl = HLT;
                    end
                end
                T4: begin
                    if (is_lda) begin
                        ctrl = MEM_EN | A_LOAD;
                        last = 1'b1;
                    end else if (is_add | is_sub) begin
                        ctrl = MEM_EN | B_LOAD;
                    end else if (is_sta) begin
                        ctrl = A_EN | MEM_ST;
                        last = 1'b1;
                    end
                end
                T5: begin
                    if (is_add) begin
                        ctrl = ADDER_EN | A_LOAD | FLAGS_LOAD;
                        last = 1'b1;
                    end else if (is_sub) begin
                        ctrl = ADDER_SUB | ADDER_EN | A_LOAD | FLAGS_LOAD;
                        last = 1'b1;
                    end
                end
                default: ctrl = 16'h0000;
            endcase
        end
    end

    assign instr_done = last;
    assign stage      = stage_q;
    assign halted     = halted_q;
    assign illegal    = illegal_q;

    // Stage and halt sequencing. This advances on the falling edge, so the
    // control word is settled for the datapath's rising edge.
    // If the opcode changes mid-instruction to one with no further work,
    // the sequencer falls back to T0.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_q   <= T0;
            halted_q  <= 1'b0;
            illegal_q <= 1'b0;
        end else if (halted_q) begin
            if (resume) begin
                halted_q <= 1'b0;
                stage_q  <= T0;
            end
        end else begin
            if (stage_q == T3 && illegal_op) begin
                illegal_q <= 1'b1;
            end
            case (stage_q)
                T0: stage_q <= T1;
                T1: stage_q <= T2;
                T2: stage_q <= T3;
                T3: begin
                    if (halt_op) begin
                        halted_q <= 1'b1;
                    end else if (!last && mem_op) begin
                        stage_q <= T4;
                    end else begin
                        stage_q <= T0;
                    end
                end
                T4:      stage_q <= (is_add | is_sub) ? T5 : T0;
                default: stage_q <= T0;
            endcase
        end
    end

endmodule
